// File: rtl/brainhack_defs.sv
// Shared opcode encoding and default widths for the brainhack loader and core.
package brainhack_defs;

    localparam int PRG_ADDR_WIDTH_DEF   = 8;
    localparam int STACK_ADDR_WIDTH_DEF = 4;

    localparam logic [2:0] OP_TERM  = 3'b000;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_RIGHT = 3'b100;
    localparam logic [2:0] OP_LEFT  = 3'b101;
    localparam logic [2:0] OP_JFWD  = 3'b110;
    localparam logic [2:0] OP_JBACK = 3'b111;

    // Non-command characters map to OP_TERM, which doubles as "not a command".
    function automatic logic [2:0] char_to_opcode(input logic [7:0] ch);
        case (ch)
            8'h2B:   char_to_opcode = OP_INC;
            8'h2D:   char_to_opcode = OP_DEC;
            8'h3E:   char_to_opcode = OP_RIGHT;
            8'h3C:   char_to_opcode = OP_LEFT;
            8'h5B:   char_to_opcode = OP_JFWD;
            8'h5D:   char_to_opcode = OP_JBACK;
            default: char_to_opcode = OP_TERM;
        endcase
    endfunction

endpackage

// File: rtl/bf_char_decode.sv
// Combinational classifier: ASCII source character to {is_cmd, is_nul, opcode}.
module bf_char_decode
    import brainhack_defs::*;
(
    input  logic [7:0] ch,
    output logic       is_cmd,
    output logic       is_nul,
    output logic [2:0] opcode
);

    // Classify the character.
    always_comb begin
        opcode = char_to_opcode(ch);
        is_cmd = (opcode != OP_TERM);
        is_nul = (ch == 8'h00);
    end

endmodule

// File: rtl/bf_loader.sv
// Streams ASCII brainhack source into program memory as 3-bit opcodes plus terminator.
// Optional bracket-nesting checker enabled by macro BF_BRACKET_CHECK_EN.
module bf_loader
    import brainhack_defs::*;
#(
    parameter int PRG_ADDR_WIDTH   = PRG_ADDR_WIDTH_DEF,
    parameter int STACK_ADDR_WIDTH = STACK_ADDR_WIDTH_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_char_valid,
    input  logic [7:0]                i_char,
    output logic                      o_char_ready,
    output logic                      o_prgmem_in,
    output logic [PRG_ADDR_WIDTH-1:0] o_prgmem_addr,
    output logic [2:0]                o_prgmem_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [PRG_ADDR_WIDTH-1:0] o_length
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_TERM = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [PRG_ADDR_WIDTH-1:0] ADDR_ONE  = {{(PRG_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRG_ADDR_WIDTH-1:0] ADDR_LAST = {PRG_ADDR_WIDTH{1'b1}};

    logic [2:0]                state_r, state_s;
    logic [PRG_ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [PRG_ADDR_WIDTH-1:0] len_r, len_s;
    logic                      wr_en_r, wr_en_s;
    logic [PRG_ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [2:0]                wr_data_r, wr_data_s;
    logic                      is_cmd_s, is_nul_s;
    logic [2:0]                opcode_s;
    logic                      accept_s;
    logic                      bracket_err_s, nul_err_s;

    bf_char_decode u_decode (
        .ch     (i_char),
        .is_cmd (is_cmd_s),
        .is_nul (is_nul_s),
        .opcode (opcode_s)
    );

    assign accept_s = i_char_valid && (state_r == ST_LOAD);

`ifdef BF_BRACKET_CHECK_EN
    localparam logic [STACK_ADDR_WIDTH:0] DEPTH_MAX = {1'b0, {STACK_ADDR_WIDTH{1'b1}}};
    localparam logic [STACK_ADDR_WIDTH:0] DEPTH_ONE = {{STACK_ADDR_WIDTH{1'b0}}, 1'b1};

    logic [STACK_ADDR_WIDTH:0] depth_r, depth_s;

    assign bracket_err_s = ((opcode_s == OP_JFWD)  && (depth_r == DEPTH_MAX)) ||
                           ((opcode_s == OP_JBACK) && (depth_r == {(STACK_ADDR_WIDTH+1){1'b0}}));
    assign nul_err_s     = (depth_r != {(STACK_ADDR_WIDTH+1){1'b0}});

    // Depth follows the brackets actually written; cleared when a load begins.
    always_comb begin
        depth_s = depth_r;
        if ((state_s == ST_LOAD) && (state_r != ST_LOAD)) begin
            depth_s = {(STACK_ADDR_WIDTH+1){1'b0}};
        end else if (wr_en_s && (wr_data_s == OP_JFWD)) begin
            depth_s = depth_r + DEPTH_ONE;
        end else if (wr_en_s && (wr_data_s == OP_JBACK)) begin
            depth_s = depth_r - DEPTH_ONE;
        end else begin
            depth_s = depth_r;
        end
    end

    // Depth register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            depth_r <= {(STACK_ADDR_WIDTH+1){1'b0}};
        end else begin
            depth_r <= depth_s;
        end
    end
`else
    logic unused_stack_cfg_s;

    assign unused_stack_cfg_s = STACK_ADDR_WIDTH[0];
    assign bracket_err_s      = 1'b0;
    assign nul_err_s          = 1'b0;
`endif

    // Next-state and write-request logic.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        len_s     = len_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    state_s = ST_LOAD;
                    addr_s  = {PRG_ADDR_WIDTH{1'b0}};
                    len_s   = {PRG_ADDR_WIDTH{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (accept_s && is_nul_s) begin
                    state_s = nul_err_s ? ST_ERR : ST_TERM;
                end else if (accept_s && is_cmd_s) begin
                    // The last slot is kept free for the terminator.
                    if ((addr_r == ADDR_LAST) || bracket_err_s) begin
                        state_s = ST_ERR;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = addr_r;
                        wr_data_s = opcode_s;
                        addr_s    = addr_r + ADDR_ONE;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_TERM: begin
                wr_en_s   = 1'b1;
                wr_addr_s = addr_r;
                wr_data_s = OP_TERM;
                len_s     = addr_r;
                state_s   = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered write port.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= {PRG_ADDR_WIDTH{1'b0}};
            len_r     <= {PRG_ADDR_WIDTH{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {PRG_ADDR_WIDTH{1'b0}};
            wr_data_r <= 3'b000;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            len_r     <= len_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    assign o_char_ready  = (state_r == ST_LOAD);
    assign o_busy        = (state_r == ST_LOAD) || (state_r == ST_TERM);
    assign o_done        = (state_r == ST_DONE);
    assign o_error       = (state_r == ST_ERR);
    assign o_prgmem_in   = wr_en_r;
    assign o_prgmem_addr = wr_addr_r;
    assign o_prgmem_data = wr_data_r;
    assign o_length      = len_r;

endmodule

// File: tb/tb_bf_loader.sv
// Directed self-checking bench for bf_loader; write log captured from the memory port.
module tb_bf_loader;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_char_valid = 1'b0;
    logic [7:0] i_char = 8'h00;
    logic       o_char_ready, o_prgmem_in, o_busy, o_done, o_error;
    logic [7:0] o_prgmem_addr, o_length;
    logic [2:0] o_prgmem_data;

    logic [3:0] wlog [0:255];
    int         wcnt;
    int         n_tests = 0;
    int         n_fail = 0;

    bf_loader dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_char_valid  (i_char_valid),
        .i_char        (i_char),
        .o_char_ready  (o_char_ready),
        .o_prgmem_in   (o_prgmem_in),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_length      (o_length)
    );

    always #5 i_clock = ~i_clock;

    // Record every write as {valid, opcode} by address.
    always @(negedge i_clock) begin
        if (o_prgmem_in === 1'b1) begin
            wlog[o_prgmem_addr] = {1'b1, o_prgmem_data};
            wcnt = wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 256; i++) wlog[i] = 4'h0;
        wcnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        i_char       = c;
        i_char_valid = 1'b1;
        @(negedge i_clock);
        i_char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_done && !o_error && n < 20) begin
            @(negedge i_clock);
            n++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_log();
        repeat (3) @(negedge i_clock);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_ready", o_char_ready, 0);
        check("rst_wr", o_prgmem_in, 0);
        check("rst_len", o_length, 0);
        i_reset_n = 1'b1;

        // "+[->]" NUL
        pulse_start();
        #1;
        check("t1_busy", o_busy, 1);
        check("t1_ready", o_char_ready, 1);
        send_str("+[->]");
        send(8'h00);
        wait_done();
        check("t1_w0", wlog[0], 4'b1010);
        check("t1_w1", wlog[1], 4'b1110);
        check("t1_w2", wlog[2], 4'b1011);
        check("t1_w3", wlog[3], 4'b1100);
        check("t1_w4", wlog[4], 4'b1111);
        check("t1_w5", wlog[5], 4'b1000);
        check("t1_cnt", wcnt, 6);
        check("t1_len", o_length, 5);
        check("t1_done", o_done, 1);
        check("t1_busy_end", o_busy, 0);

        // restart from DONE with "-"
        clear_log();
        pulse_start();
        #1;
        check("t2_done_clr", o_done, 0);
        check("t2_len_clr", o_length, 0);
        send("-");
        send(8'h00);
        wait_done();
        check("t2_w0", wlog[0], 4'b1011);
        check("t2_w1", wlog[1], 4'b1000);
        check("t2_cnt", wcnt, 2);
        check("t2_len", o_length, 1);

        // non-command characters consumed silently
        clear_log();
        pulse_start();
        send_str("a+ b\n<");
        send(8'h00);
        wait_done();
        check("t3_w0", wlog[0], 4'b1010);
        check("t3_w1", wlog[1], 4'b1101);
        check("t3_w2", wlog[2], 4'b1000);
        check("t3_cnt", wcnt, 3);
        check("t3_len", o_length, 2);

        // unmatched "]"
        clear_log();
        pulse_start();
        send("]");
        @(negedge i_clock);
        #1;
`ifdef BF_BRACKET_CHECK_EN
        check("t4_err", o_error, 1);
        check("t4_ready", o_char_ready, 0);
        check("t4_cnt", wcnt, 0);
        clear_log();
        pulse_start();
        #1;
        check("t4b_err_clr", o_error, 0);
        send("[");
        send(8'h00);
        wait_done();
        check("t4b_err", o_error, 1);
        check("t4b_cnt", wcnt, 1);
        check("t4b_noterm", wlog[1], 4'b0000);
`else
        check("t4_err", o_error, 0);
        send(8'h00);
        wait_done();
        check("t4_w0", wlog[0], 4'b1111);
        check("t4_w1", wlog[1], 4'b1000);
        check("t4_len", o_length, 1);
`endif

        // stall then async reset mid-load with a write pending
        clear_log();
        pulse_start();
        send_str("++");
        i_char = "-";
        repeat (10) @(negedge i_clock);
        #1;
        check("t5_stall_cnt", wcnt, 2);
        send("-");
        #1;
        check("t5_w2", wlog[2], 4'b1011);
        send("+");
        #1;
        check("t5_pending", o_prgmem_in, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("t5_rst_wr", o_prgmem_in, 0);
        check("t5_rst_addr", o_prgmem_addr, 0);
        check("t5_rst_data", o_prgmem_data, 0);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_ready", o_char_ready, 0);
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;

        // fill program memory to the reserved last slot
        clear_log();
        pulse_start();
        repeat (255) send("+");
        #1;
        check("t6_err_early", o_error, 0);
        check("t6_cnt", wcnt, 255);
        check("t6_w254", wlog[254], 4'b1010);
        send("+");
        #1;
        check("t6_err", o_error, 1);
        check("t6_busy", o_busy, 0);
        @(negedge i_clock);
        #1;
        check("t6_nowrite", wlog[255], 4'b0000);
        check("t6_cnt_end", wcnt, 255);
        pulse_start();
        #1;
        check("t6_restart", o_busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_loader.md
BF_LOADER -- requirements
Module: bf_loader

Interface
REQ-001 Parameter PRG_ADDR_WIDTH, default 8, sets the program-memory address width (256 slots).
REQ-002 Parameter STACK_ADDR_WIDTH, default 4, sets the maximum `[` nesting depth, 2^STACK_ADDR_WIDTH-1 = 15.
REQ-003 i_clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_start  in  1  one-cycle request to begin a load; ignored while loading.
REQ-006 i_char_valid  in  1  source has a character on i_char.
REQ-007 i_char  in  8  ASCII source character.
REQ-008 o_char_ready  out  1  loader accepts i_char this cycle.
REQ-009 o_prgmem_in  out  1  program-memory write strobe.
REQ-010 o_prgmem_addr  out  PRG_ADDR_WIDTH  write address.
REQ-011 o_prgmem_data  out  3  opcode to write.
REQ-012 o_busy / o_done / o_error  out  1 each  state flags.
REQ-013 o_length  out  PRG_ADDR_WIDTH  number of command opcodes written, excluding the terminator.

Function
REQ-014 Opcodes SHALL be: `+`=010, `-`=011, `>`=100, `<`=101, `[`=110, `]`=111, terminator=000.
REQ-015 FSM states SHALL be IDLE, LOAD, TERM, DONE and ERR.
REQ-016 IDLE: ready=0. On i_start the FSM SHALL go to LOAD and clear the address, depth, length and error.
REQ-017 LOAD: o_char_ready=1. A character is accepted only when i_char_valid && o_char_ready.
REQ-018 For an accepted command character, the opcode SHALL be written one cycle later (registered strobe, data and address), and then the address increments.
REQ-019 Accepted characters other than the six commands and NUL SHALL be consumed with no write.
REQ-020 Accepted NUL (0x00) SHALL move the FSM to TERM.
REQ-021 TERM: in one cycle, write 000 at the current address, latch o_length = address, then go to DONE.
REQ-022 DONE: o_done=1 and held; i_start returns the FSM to LOAD (restart).
REQ-023 A command accepted at address 2^PRG_ADDR_WIDTH-1 SHALL go to ERR with no write, because the last slot is reserved for the terminator.
REQ-024 ERR: o_error=1, ready=0, no writes; i_start restarts into LOAD.
REQ-025 o_busy SHALL be 1 in LOAD and TERM and 0 elsewhere.
REQ-026 o_prgmem_in SHALL never be asserted for more than one cycle per accepted command, or per terminator.

Reset
REQ-027 While i_reset_n=0: state IDLE; all outputs 0; address, depth and length 0. This applies immediately, including mid-load.
REQ-028 A write pending at reset SHALL be discarded.

Configuration
REQ-029 Macro BF_BRACKET_CHECK_EN, when defined, SHALL enable a depth counter of STACK_ADDR_WIDTH+1 bits: `[` increments it, `]` decrements it.
- `[` at depth 15 → ERR.
- `]` at depth 0 → ERR.
- NUL at depth ≠ 0 → ERR, with no terminator written.
- The offending character is never written.
REQ-030 Without BF_BRACKET_CHECK_EN, no depth counter exists; brackets are written unchecked and only REQ-023 produces ERR.

Structure
REQ-031 Opcode constants, the terminator code and default widths SHALL live in the shared defines package brainhack_defs, shared with the core.
REQ-032 A purely combinational sub-module bf_char_decode SHALL map i_char to {is_cmd, is_nul, opcode}.
- The FSM, address counter, depth counter and write register live in bf_loader.

Verification
REQ-033 Load "+[->]" then NUL:
- Writes 010,110,011,100,111 at addresses 0–4, then 000 at address 5.
- o_length=5, o_done=1.
REQ-034 Load "a+ b\n<" then NUL: writes 010,101 at addresses 0–1 and the terminator at 2; o_length=2.
REQ-035 With BF_BRACKET_CHECK_EN, load "]": o_error=1 and no write. With the macro undefined, the same input writes 111 at address 0.
REQ-036 Stream 255 `+` characters and then one more:
- Addresses 0–254 are written.
- The 256th command sets o_error with no write at address 255.
REQ-037 Hold i_char_valid=0 for 10 cycles mid-load: no writes and the address is unchanged. Then assert reset during LOAD: all outputs are 0 asynchronously and the FSM is in IDLE.
REQ-038 From DONE, pulse i_start and load "-" then NUL: writes 011 at address 0 and 000 at address 1; o_length=1.
